plru_state_array: RTL

//   Per-set storage for the 4-way tree-PLRU state (3 bits/set) of one cache.

---
 rtl/plru_state_array_pkg.sv | 7 +
 rtl/plru_state_array_if.sv | 18 +
 rtl/plru_state_array_mem.sv | 21 ++
 rtl/plru_state_array.sv | 113 +++++++++++
 4 files changed

// File: rtl/plru_state_array_pkg.sv
// Shared types for the tree-PLRU state array: 3-bit per-set state, init value, FSM states.
package plru_state_array_pkg;
  localparam int LRU_W = 3;
  typedef logic [LRU_W-1:0] lru_bits_t;
  localparam lru_bits_t LRU_INIT = 3'b000;
  typedef enum logic [1:0] {ST_INIT, ST_RUN, ST_DRAIN} state_t;
endpackage

// File: rtl/plru_state_array_if.sv
// Lookup / writeback bus between the replacement logic (master) and the PLRU array (slave).
interface plru_state_array_if #(parameter int NUM_SETS = 64);
  import plru_state_array_pkg::*;
  localparam int SET_W = $clog2(NUM_SETS);

  logic             req_valid;
  logic             req_ready;
  logic [SET_W-1:0] req_set;
  logic             lru_valid;
  lru_bits_t        old_lru_bits;
  lru_bits_t        new_lru_bits;
  logic             init_done;

  modport master (output req_valid, req_set, new_lru_bits,
                  input  req_ready, lru_valid, old_lru_bits, init_done);
  modport slave  (input  req_valid, req_set, new_lru_bits,
                  output req_ready, lru_valid, old_lru_bits, init_done);
endinterface

// File: rtl/plru_state_array_mem.sv
// NUM_SETS x 3-bit flop array: one synchronous read port, one write port.
module plru_mem
  import plru_state_array_pkg::*;
#(
  parameter int NUM_SETS = 64
) (
  input  logic                        clk,
  input  logic [$clog2(NUM_SETS)-1:0] rd_addr,
  output lru_bits_t                   rd_data,
  input  logic                        we,
  input  logic [$clog2(NUM_SETS)-1:0] waddr,
  input  lru_bits_t                   wdata
);
  lru_bits_t mem [NUM_SETS];

  // Read returns the pre-write contents on a same-edge collision; the parent forwards.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rd_data <= mem[rd_addr];
  end
endmodule

// File: rtl/plru_state_array.sv
// Per-set tree-PLRU state with init/flush sweep and same-set hazard handling.
// Define PLRU_BYPASS_EN to forward writebacks instead of stalling hazarding lookups.
module plru_state_array
  import plru_state_array_pkg::*;
#(
  parameter int NUM_SETS = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  plru_state_array_if.slave  bus
);
  localparam int SET_W = $clog2(NUM_SETS);

  state_t           state;
  logic [SET_W-1:0] sweep_idx;
  logic             init_done_q, run_q;
  logic             s1_valid, s2_valid;
  logic [SET_W-1:0] s1_set, s2_set;
  lru_bits_t        rd_data, s1_bits;
  logic             hazard, accept;
  logic             mem_we;
  logic [SET_W-1:0] mem_waddr;
  lru_bits_t        mem_wdata;

  assign accept = bus.req_valid && bus.req_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_INIT;
      sweep_idx   <= '0;
      init_done_q <= 1'b0;
      run_q       <= 1'b0;
    end else begin
      case (state)
        ST_INIT: begin
          if (flush) sweep_idx <= '0;
          else if (sweep_idx == SET_W'(NUM_SETS-1)) begin
            state       <= ST_RUN;
            sweep_idx   <= '0;
            init_done_q <= 1'b1;
            run_q       <= 1'b1;
          end else sweep_idx <= sweep_idx + 1'b1;
        end
        ST_RUN: if (flush) begin
          state       <= ST_DRAIN;
          init_done_q <= 1'b0;
          run_q       <= 1'b0;
        end
        ST_DRAIN: if (!s1_valid && !s2_valid) begin
          state     <= ST_INIT;
          sweep_idx <= '0;
        end
        default: state <= ST_INIT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else begin
      s1_valid <= accept;
      s2_valid <= s1_valid;
    end
    if (accept) s1_set <= bus.req_set;
    s2_set <= s1_set;
  end

`ifdef PLRU_BYPASS_EN
  logic      fwd_q;
  lru_bits_t fwd_bits;

  assign hazard = 1'b0;

  // dist-2: the S2 writeback lands on the read edge, so capture it instead of mem.
  always_ff @(posedge clk) begin
    if (rst) fwd_q <= 1'b0;
    else if (accept) begin
      fwd_q    <= s2_valid && (s2_set == bus.req_set);
      fwd_bits <= bus.new_lru_bits;
    end
  end

  // dist-1 is the newest value and wins over a captured dist-2 value.
  assign s1_bits = (s2_valid && s2_set == s1_set) ? bus.new_lru_bits :
                   fwd_q                          ? fwd_bits         : rd_data;
`else
  assign hazard  = (s1_valid && s1_set == bus.req_set) ||
                   (s2_valid && s2_set == bus.req_set);
  assign s1_bits = rd_data;
`endif

  assign bus.req_ready    = run_q && !hazard;
  assign bus.lru_valid    = s1_valid;
  assign bus.old_lru_bits = s1_valid ? s1_bits : LRU_INIT;
  assign bus.init_done    = init_done_q;

  // Sweep owns the write port in INIT; the pipeline is empty there by construction.
  assign mem_we    = !rst && (state == ST_INIT || s2_valid);
  assign mem_waddr = (state == ST_INIT) ? sweep_idx : s2_set;
  assign mem_wdata = (state == ST_INIT) ? LRU_INIT  : bus.new_lru_bits;

  plru_mem #(.NUM_SETS(NUM_SETS)) u_mem (
    .clk     (clk),
    .rd_addr (bus.req_set),
    .rd_data (rd_data),
    .we      (mem_we),
    .waddr   (mem_waddr),
    .wdata   (mem_wdata)
  );
endmodule
